// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : arb_pkg
// Purpose : Shared constants and helpers for the arbiter and its egress buffer.
// Revision: 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int ARB_WIDTH        = 64;
    localparam int ARB_FIFO_DEPTH   = 8;
    localparam int ARB_GRANT_MARGIN = 2;

    // Ceiling log2, usable in constant expressions (port widths, localparams).
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/egress_fifo_core.sv
`default_nettype none
// ============================================================================
// Module  : egress_fifo_core
// Purpose : First-word-fall-through storage with wrap-bit pointers and level.
// Revision: 1.0 - initial release
// ============================================================================
module egress_fifo_core
    import arb_pkg::*;
#(
    parameter int WIDTH = ARB_WIDTH,
    parameter int DEPTH = ARB_FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_wr_en,
    input  logic [WIDTH-1:0]        i_wr_data,
    input  logic                    i_rd_en,
    output logic [WIDTH-1:0]        o_rd_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [clog2(DEPTH):0]   o_level
);

    localparam int AW = clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_rd_en) r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // Storage is not reset: stale contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                       (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign o_level   = r_wr_ptr - r_rd_ptr;

endmodule
`default_nettype wire

// File: rtl/arb_egress_buffer.sv
`default_nettype none
// ============================================================================
// Module  : arb_egress_buffer
// Purpose : Egress FIFO after the round-robin arbiter with credit-style grant,
//           beat counter and sticky overflow status.
// Revision: 1.0 - initial release
// ============================================================================
module arb_egress_buffer
    import arb_pkg::*;
#(
    parameter int WIDTH        = ARB_WIDTH,
    parameter int DEPTH        = ARB_FIFO_DEPTH,
    parameter int GRANT_MARGIN = ARB_GRANT_MARGIN
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic                    i_Valid,
    input  logic [WIDTH-1:0]        i_Data,
    output logic                    o_Grant,
    output logic                    o_Valid,
    output logic [WIDTH-1:0]        o_Data,
    input  logic                    i_Ready,
    output logic [clog2(DEPTH):0]   o_Level,
    output logic [31:0]             o_BeatCnt,
    output logic                    o_Overflow
);

    localparam int PW = clog2(DEPTH) + 1;

    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [PW-1:0] w_level;
    logic [PW-1:0] w_level_next;
    logic [PW-1:0] w_free_next;
    logic          r_grant;
    logic [31:0]   r_beat_cnt;
    logic          r_overflow;

    egress_fifo_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_core (
        .clk       (CLK),
        .rst       (Reset),
        .i_wr_en   (w_push),
        .i_wr_data (i_Data),
        .i_rd_en   (w_pop),
        .o_rd_data (o_Data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (w_level)
    );

    // A pop frees a slot in the same edge, so a full FIFO still accepts.
    assign w_pop        = !w_empty && i_Ready;
    assign w_push       = i_Valid && (!w_full || w_pop);
    assign w_level_next = w_level + PW'(w_push) - PW'(w_pop);
    assign w_free_next  = PW'(DEPTH) - w_level_next;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_grant    <= 1'b0;
            r_beat_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_grant <= (w_free_next >= PW'(GRANT_MARGIN));
            if (w_pop) r_beat_cnt <= r_beat_cnt + 32'd1;
            if (i_Valid && !w_push) r_overflow <= 1'b1;
        end
    end

    assign o_Valid    = !w_empty;
    assign o_Level    = w_level;
    assign o_Grant    = r_grant;
    assign o_BeatCnt  = r_beat_cnt;
    assign o_Overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_arb_egress_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_arb_egress_buffer
// Purpose : Directed and randomized checks of arb_egress_buffer against a
//           queue-based model of the buffer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_arb_egress_buffer;

    localparam int WIDTH  = 64;
    localparam int DEPTH  = 8;
    localparam int MARGIN = 2;

    logic             CLK = 1'b0;
    logic             Reset;
    logic             i_Valid;
    logic [WIDTH-1:0] i_Data;
    logic             o_Grant;
    logic             o_Valid;
    logic [WIDTH-1:0] o_Data;
    logic             i_Ready;
    logic [3:0]       o_Level;
    logic [31:0]      o_BeatCnt;
    logic             o_Overflow;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model: contents as a queue plus plain status variables.
    logic [WIDTH-1:0] m_q [$];
    bit               m_grant = 1'b0;
    logic [31:0]      m_beats = '0;
    bit               m_ovf   = 1'b0;

    arb_egress_buffer #(
        .WIDTH        (WIDTH),
        .DEPTH        (DEPTH),
        .GRANT_MARGIN (MARGIN)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .i_Valid    (i_Valid),
        .i_Data     (i_Data),
        .o_Grant    (o_Grant),
        .o_Valid    (o_Valid),
        .o_Data     (o_Data),
        .i_Ready    (i_Ready),
        .o_Level    (o_Level),
        .o_BeatCnt  (o_BeatCnt),
        .o_Overflow (o_Overflow)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK) begin
        bit pop;
        bit push;
        if (Reset) begin
            m_q.delete();
            m_grant = 1'b0;
            m_beats = '0;
            m_ovf   = 1'b0;
        end else begin
            pop  = (m_q.size() > 0) && i_Ready;
            push = i_Valid && ((m_q.size() < DEPTH) || pop);
            if (i_Valid && !push) m_ovf = 1'b1;
            if (pop) begin
                void'(m_q.pop_front());
                m_beats = m_beats + 32'd1;
            end
            if (push) m_q.push_back(i_Data);
            m_grant = (DEPTH - m_q.size()) >= MARGIN;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("valid",    64'(o_Valid),    64'(m_q.size() != 0));
            chk("level",    64'(o_Level),    64'(m_q.size()));
            chk("grant",    64'(o_Grant),    64'(m_grant));
            chk("beatcnt",  64'(o_BeatCnt),  64'(m_beats));
            chk("overflow", 64'(o_Overflow), 64'(m_ovf));
            if (m_q.size() != 0) chk("data", o_Data, m_q[0]);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        Reset   = 1'b1;
        i_Valid = 1'b1;
        i_Data  = 64'h55;
        i_Ready = 1'b0;

        // Reset held two cycles with valid asserted
        step();
        chk_en = 1'b1;
        step();
        chk("rst_valid", 64'(o_Valid),    64'd0);
        chk("rst_grant", 64'(o_Grant),    64'd0);
        chk("rst_level", 64'(o_Level),    64'd0);
        chk("rst_beats", 64'(o_BeatCnt),  64'd0);
        chk("rst_ovf",   64'(o_Overflow), 64'd0);
        Reset   = 1'b0;
        i_Valid = 1'b0;
        step();
        chk("grant_after_rst", 64'(o_Grant), 64'd1);

        // Fill with 1..8, consumer stalled
        for (int k = 1; k <= 8; k++) begin
            i_Valid = 1'b1;
            i_Data  = 64'(k);
            step();
            chk("fill_level", 64'(o_Level), 64'(k));
            chk("fill_head",  o_Data,       64'h1);
            chk("fill_grant", 64'(o_Grant), 64'((DEPTH - k) >= MARGIN));
        end

        // Write while full is dropped
        i_Data = 64'hDEAD;
        step();
        chk("ovf_level", 64'(o_Level),    64'd8);
        chk("ovf_flag",  64'(o_Overflow), 64'd1);
        i_Valid = 1'b0;
        i_Ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            chk("drain_valid", 64'(o_Valid), 64'd1);
            chk("drain_data",  o_Data,       64'(k));
            step();
        end
        chk("drained", 64'(o_Valid), 64'd0);

        // Push and pop together at full
        i_Ready = 1'b0;
        i_Valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            i_Data = 64'h100 + 64'(k);
            step();
        end
        i_Ready = 1'b1;
        i_Data  = 64'h1FF;
        step();
        chk("fullpp_level", 64'(o_Level),    64'd8);
        chk("fullpp_ovf",   64'(o_Overflow), 64'd1);
        chk("fullpp_head",  o_Data,          64'h101);
        i_Valid = 1'b0;
        repeat (8) step();
        chk("fullpp_empty", 64'(o_Level), 64'd0);

        // Mid-operation reset at level 5
        i_Ready = 1'b0;
        i_Valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            i_Data = 64'hBAD0 + 64'(k);
            step();
        end
        chk("pre_rst_level", 64'(o_Level), 64'd5);
        i_Valid = 1'b0;
        Reset   = 1'b1;
        step();
        Reset = 1'b0;
        chk("midrst_valid", 64'(o_Valid), 64'd0);
        chk("midrst_level", 64'(o_Level), 64'd0);

        // Streaming 100 beats
        i_Valid = 1'b1;
        i_Ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            i_Data = 64'h1000 + 64'(k);
            step();
            chk("stream_level", 64'(o_Level <= 4'd1), 64'd1);
            chk("stream_grant", 64'(o_Grant),        64'd1);
            if (k == 0) chk("stream_first", o_Data, 64'h1000);
        end
        i_Valid = 1'b0;
        step();
        chk("stream_beats", 64'(o_BeatCnt), 64'd100);

        // Randomized traffic, mostly grant-compliant, with rare resets
        for (int c = 0; c < 3000; c++) begin
            Reset   = ($urandom_range(0, 399) == 0);
            i_Valid = o_Grant ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            i_Ready = ($urandom_range(0, 2) != 0);
            i_Data  = {$urandom, $urandom};
            step();
        end
        Reset   = 1'b0;
        i_Valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
